// File: rtl/pkt_checker.sv
// pkt_checker: locks onto an all-lanes header beat, then checks the lane-indexed
// incrementing count in the data beats that follow and reports packets and errors.
module pkt_checker #(
    parameter int unsigned DIN_WIDTH = 32,
    parameter int unsigned PARALLEL  = 4,
    parameter logic [31:0] HEADER    = 32'haabbccdd
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clear,
    input  logic [31:0]                   pkt_len,
    input  logic [DIN_WIDTH*PARALLEL-1:0] din,
    input  logic                          din_valid,
    output logic                          locked,
    output logic                          pkt_done,
    output logic [31:0]                   pkt_count,
    output logic                          err_pulse,
    output logic [1:0]                    err_type,
    output logic [PARALLEL-1:0]           err_lanes,
    output logic [31:0]                   err_count
);

    localparam logic [DIN_WIDTH-1:0] HDR  = DIN_WIDTH'(HEADER);
    localparam logic [DIN_WIDTH-1:0] STEP = DIN_WIDTH'(PARALLEL);

    typedef enum logic [0:0] {
        StSearch,
        StData
    } state_e;

    typedef enum logic [1:0] {
        ErrStray = 2'd0,
        ErrData  = 2'd1,
        ErrEarly = 2'd2,
        ErrShort = 2'd3
    } err_e;

    state_e               state_q, state_d;
    logic [31:0]          beat_q, beat_d;
    logic [DIN_WIDTH-1:0] exp_q, exp_d;
    logic [31:0]          len_q, len_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 err_pulse_q, err_pulse_d;
    err_e                 err_type_q, err_type_d;
    logic [PARALLEL-1:0]  err_lanes_q, err_lanes_d;
    logic [31:0]          pkt_count_q, pkt_count_d;
    logic [31:0]          err_count_q, err_count_d;

    logic                 is_header;
    logic [PARALLEL-1:0]  mismatch;

    // Per-lane header detection and ramp comparison against exp+k.
    always_comb begin
        is_header = 1'b1;
        mismatch  = '0;
        for (int k = 0; k < PARALLEL; k++) begin
            if (din[DIN_WIDTH*k +: DIN_WIDTH] != HDR) begin
                is_header = 1'b0;
            end
            mismatch[k] = (din[DIN_WIDTH*k +: DIN_WIDTH] != (exp_q + DIN_WIDTH'(k)));
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        exp_d       = exp_q;
        len_d       = len_q;
        pkt_done_d  = 1'b0;
        err_pulse_d = 1'b0;
        err_type_d  = err_type_q;
        err_lanes_d = err_lanes_q;

        if (en) begin
            unique case (state_q)
                StSearch: begin
                    if (din_valid) begin
                        if (is_header) begin
                            if (pkt_len == 32'd0) begin
                                pkt_done_d = 1'b1;
                            end else begin
                                len_d   = pkt_len;
                                beat_d  = '0;
                                exp_d   = '0;
                                state_d = StData;
                            end
                        end else begin
                            err_pulse_d = 1'b1;
                            err_type_d  = ErrStray;
                        end
                    end
                end
                StData: begin
                    if (!din_valid) begin
                        // The generator never gaps inside a packet.
                        err_pulse_d = 1'b1;
                        err_type_d  = ErrShort;
                        state_d     = StSearch;
                    end else if (is_header) begin
                        err_pulse_d = 1'b1;
                        err_type_d  = ErrEarly;
                        len_d       = pkt_len;
                        beat_d      = '0;
                        exp_d       = '0;
                    end else begin
                        if (|mismatch) begin
                            err_pulse_d = 1'b1;
                            err_type_d  = ErrData;
                            err_lanes_d = mismatch;
                        end
                        exp_d  = exp_q + STEP;
                        beat_d = beat_q + 32'd1;
                        if (beat_q + 32'd1 == len_q) begin
                            pkt_done_d = 1'b1;
                            state_d    = StSearch;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end

        pkt_count_d = pkt_count_q;
        if (pkt_done_d && (pkt_count_q != 32'hffffffff)) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        err_count_d = err_count_q;
        if (err_pulse_d && (err_count_q != 32'hffffffff)) begin
            err_count_d = err_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StSearch;
            beat_q      <= '0;
            exp_q       <= '0;
            len_q       <= '0;
            pkt_done_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_type_q  <= ErrStray;
            err_lanes_q <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else if (clear) begin
            state_q     <= StSearch;
            beat_q      <= '0;
            exp_q       <= '0;
            len_q       <= '0;
            pkt_done_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_type_q  <= ErrStray;
            err_lanes_q <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            exp_q       <= exp_d;
            len_q       <= len_d;
            pkt_done_q  <= pkt_done_d;
            err_pulse_q <= err_pulse_d;
            err_type_q  <= err_type_d;
            err_lanes_q <= err_lanes_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == StData);
    assign pkt_done  = pkt_done_q;
    assign err_pulse = err_pulse_q;
    assign err_type  = err_type_q;
    assign err_lanes = err_lanes_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;

endmodule

// File: doc/pkt_checker.md
# pkt_checker

Stream checker sitting directly downstream of the test packet generator in the 10GbE write-packetizer test setup. It consumes the `PARALLEL`-lane data bus plus valid and locks onto the header beat, where every lane equals `HEADER`. It then checks that each following beat carries the lane-indexed incrementing count. It reports completed packets, error counts and error details, so a hardware or simulation run can be scored without inspecting waveforms.

## Interface
- `DIN_WIDTH`, 32: lane width in bits.
- `PARALLEL`, 4: number of lanes per beat.
- `HEADER`, 32'haabbccdd: header marker; compared as `HEADER[DIN_WIDTH-1:0]` on every lane.
- `clk`  in  1: sole clock, all logic on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `en`  in  1: when low, inputs are ignored and all state is held.
- `clear`  in  1: synchronous clear; same effect as reset, lower priority than `rst_n`, honoured regardless of `en`.
- `pkt_len`  in  32: expected data beats per packet, excluding the header; sampled on the header beat.
- `din`  in  DIN_WIDTH*PARALLEL: lane k occupies `din[DIN_WIDTH*k +: DIN_WIDTH]`.
- `din_valid`  in  1: beat qualifier.
- `locked`  out  1: high while in DATA state.
- `pkt_done`  out  1: one-cycle pulse when a packet completes.
- `pkt_count`  out  32: completed packets; saturates at 32'hffffffff.
- `err_pulse`  out  1: one-cycle pulse per detected error.
- `err_type`  out  2: type of the most recent error. 0 = stray beat, 1 = data mismatch, 2 = early header, 3 = short packet.
- `err_lanes`  out  PARALLEL: mismatching-lane mask of the most recent type-1 error.
- `err_count`  out  32: total errors; saturates at 32'hffffffff.

## Operation
- Two states: SEARCH (reset state) and DATA.
- Internal registers: beat counter `beat` (32b), expected base `exp` (DIN_WIDTH), latched length `len` (32b).
- SEARCH, with `en` and `din_valid`:
  - Header beat (all lanes == HEADER) with `pkt_len`==0: `pkt_done` and `pkt_count`++; stay in SEARCH.
  - Header beat with `pkt_len`>0: latch `len`; `beat`=0, `exp`=0; go to DATA.
  - Any other valid beat: error type 0; stay in SEARCH.
- DATA, with `en` and `din_valid`:
  - Header beat: error type 2. Relatch `len` from `pkt_len`; `beat`=0, `exp`=0; stay in DATA.
  - Data beat: lane k is expected to equal `exp+k`, mod 2^DIN_WIDTH.
  - On any mismatching lane: error type 1, `err_lanes` = mismatch mask. At most one error per beat.
  - After every data beat, matching or not: `exp` += PARALLEL (wraps mod 2^DIN_WIDTH) and `beat`++.
  - When the beat just checked is number `len` (`beat`+1 == `len`): `pkt_done`, `pkt_count`++, go to SEARCH.
  - A packet that contains mismatches still counts as completed.
- DATA, with `en` and `!din_valid`: error type 3 (short packet); go to SEARCH. The generator holds valid continuously within a packet, so any gap is an error.
- `en` low: no checks, no counter updates; valid gaps are not flagged.
- Every error: `err_pulse` for one cycle, `err_type` updated, `err_count`++ (saturating).
- `err_lanes` changes only on type-1 errors.

## Timing
- All outputs are registered.
- Response to a beat sampled at edge N is visible after edge N+1: one-cycle latency for `pkt_done`, `err_pulse`, counters, `err_type`, `err_lanes`, `locked`.
- `locked` rises the cycle after the header beat and falls the cycle after the final data beat or the gap.
- Back-to-back packets are supported: a header beat directly following the final data beat is accepted in SEARCH with no dead cycle.
- Reset values (both `rst_n` low and `clear`): state SEARCH, all outputs 0, `beat`/`exp`/`len` 0.
- `rst_n` mid-packet clears outputs immediately (asynchronously) and drops the packet; no error is recorded.
- Counter saturation: a saturated counter holds its value; the pulses still fire.

## Test plan
- Reset/idle:
  - `rst_n`=0 -> all outputs 0.
  - Release reset, drive 10 idle cycles -> outputs remain 0, `locked`=0.
- Good packet:
  - PARALLEL=4, `pkt_len`=5; header beat, then beats {0,1,2,3} .. {16,17,18,19} -> `locked` for 5 cycles.
  - `pkt_done` one cycle after the 5th data beat; `pkt_count`=1, `err_count`=0.
  - Repeat back-to-back 3 times -> `pkt_count`=4.
- Data corruption: lane 2 of data beat 3 driven 0 instead of 14 -> single `err_pulse`, `err_type`=1, `err_lanes`=4'b0100, `err_count`=1; packet still completes, `pkt_count`=1.
- Short packet: valid dropped after 3 data beats -> `err_type`=3, `err_count`=1, `pkt_count`=0, `locked`=0. Next full packet -> `pkt_count`=1.
- Early header: header reinserted after 2 data beats, followed by 5 good beats -> `err_type`=2, `err_count`=1, `pkt_count`=1.
- Edge cases:
  - Stray beat {7,7,7,7} in SEARCH -> `err_type`=0, `err_count`=1.
  - `pkt_len`=0: header alone -> `pkt_done`, `locked` never rises.
  - `rst_n` pulsed during data beat 2 -> all counters 0, SEARCH.
  - `en` low for 4 cycles mid-packet, then good beats resume -> no error, `pkt_count`=1.
